// File: rtl/writeback_regfile.sv
// Writeback stage and architectural register file.
// Takes execute results through a valid/ready handshake into a one-entry
// latch and commits the latch into a 16x64 GPR file. Keeps a per-register
// pending-write scoreboard for decode, and serves two read ports that
// bypass from the latch.
module writeback_regfile #(
   parameter int unsigned NUM_REGS  = 16,
   parameter logic [63:0] RSP_RESET = 64'h0000_0000_0000_F000,
   parameter int unsigned SB_MAX    = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ex_valid,
   output logic                ex_ready,
   input  logic                ex_write_en,
   input  logic [3:0]          ex_dest_reg,
   input  logic [63:0]         ex_alu_result,
   input  logic                ex_dest_reg_special_valid,
   input  logic [3:0]          ex_dest_reg_special,
   input  logic [63:0]         ex_alu_result_special,
   input  logic                wb_stall,
   input  logic                iss_valid,
   output logic                iss_ready,
   input  logic                iss_write_en,
   input  logic [3:0]          iss_dest_reg,
   input  logic                iss_dest_special_valid,
   input  logic [3:0]          iss_dest_special,
   output logic [NUM_REGS-1:0] reg_busy,
   input  logic [3:0]          rd_addr1,
   input  logic [3:0]          rd_addr2,
   output logic [63:0]         rd_data1,
   output logic [63:0]         rd_data2,
   output logic                sb_error
);

   localparam int         NR      = NUM_REGS;
   localparam logic [1:0] SB_FULL = 2'(SB_MAX);

   // One pending writeback: primary result plus optional secondary result.
   typedef struct packed {
      logic        write_en;
      logic [3:0]  dest;
      logic [63:0] result;
      logic        spec_valid;
      logic [3:0]  spec_dest;
      logic [63:0] spec_result;
   } wb_entry_t;

   logic          latch_valid_q, latch_valid_d;
   wb_entry_t     latch_q, latch_d;
   logic [63:0]   regs_q [NR];
   logic [63:0]   regs_d [NR];
   logic [1:0]    cnt_q  [NR];
   logic [1:0]    cnt_d  [NR];
   logic          sb_error_q, sb_error_d;

   logic          commit;
   logic          accept;
   logic          issue;
   logic          iss_full;
   logic [NR-1:0] inc;
   logic [NR-1:0] dec;

   // Handshake conditions; both readies are held low while reset is asserted.
   always_comb begin
      commit   = latch_valid_q && !wb_stall;
      ex_ready = reset && (!latch_valid_q || !wb_stall);
      accept   = ex_valid && ex_ready;
      iss_full = (iss_write_en && (cnt_q[iss_dest_reg] == SB_FULL)) ||
                 (iss_dest_special_valid && (cnt_q[iss_dest_special] == SB_FULL));
      iss_ready = reset && !iss_full;
      issue    = iss_valid && iss_ready;
   end

   // Per-register increment (issue) and decrement (commit) requests; a
   // register named twice in one event is only counted once.
   always_comb begin
      // NOTE: every signal gets a default before the conditional updates so
      // that no path leaves it unassigned, which would infer a latch.
      inc = '0;
      dec = '0;
      if (issue) begin
         if (iss_write_en)           inc[iss_dest_reg]     = 1'b1;
         if (iss_dest_special_valid) inc[iss_dest_special] = 1'b1;
      end
      if (commit) begin
         if (latch_q.write_en)   dec[latch_q.dest]      = 1'b1;
         if (latch_q.spec_valid) dec[latch_q.spec_dest] = 1'b1;
      end
   end

   // Next state of the latch, register file, scoreboard and error flag.
   always_comb begin
      latch_valid_d = latch_valid_q;
      latch_d       = latch_q;
      regs_d        = regs_q;
      cnt_d         = cnt_q;
      sb_error_d    = sb_error_q;

      if (commit) begin
         latch_valid_d = 1'b0;
         // Secondary first so the primary value wins on a shared destination.
         if (latch_q.spec_valid) regs_d[latch_q.spec_dest] = latch_q.spec_result;
         if (latch_q.write_en)   regs_d[latch_q.dest]      = latch_q.result;
         if (latch_q.write_en && latch_q.spec_valid && (latch_q.dest == latch_q.spec_dest))
            sb_error_d = 1'b1;
      end

      // An accept on the commit edge refills the latch with no bubble.
      if (accept) begin
         latch_valid_d       = 1'b1;
         latch_d.write_en    = ex_write_en;
         latch_d.dest        = ex_dest_reg;
         latch_d.result      = ex_alu_result;
         latch_d.spec_valid  = ex_dest_reg_special_valid;
         latch_d.spec_dest   = ex_dest_reg_special;
         latch_d.spec_result = ex_alu_result_special;
      end

      for (int i = 0; i < NR; i++) begin
         if (dec[i] && (cnt_q[i] == 2'd0)) sb_error_d = 1'b1;
         if (inc[i] && !dec[i]) begin
            cnt_d[i] = cnt_q[i] + 2'd1;
         end else if (dec[i] && !inc[i] && (cnt_q[i] != 2'd0)) begin
            cnt_d[i] = cnt_q[i] - 2'd1;
         end
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples its pre-edge inputs regardless of statement order.
      if (!reset) begin
         latch_valid_q <= 1'b0;
         latch_q       <= '0;
         sb_error_q    <= 1'b0;
         for (int i = 0; i < NR; i++) begin
            // NOTE: the register file is built from flops and reset on purpose,
            // because RSP must come up holding a non-zero stack pointer.
            regs_q[i] <= (i == 4) ? RSP_RESET : 64'd0;
            cnt_q[i]  <= 2'd0;
         end
      end else begin
         latch_valid_q <= latch_valid_d;
         latch_q       <= latch_d;
         sb_error_q    <= sb_error_d;
         regs_q        <= regs_d;
         cnt_q         <= cnt_d;
      end
   end

   // Read ports: latch primary beats latch secondary beats register file.
   always_comb begin
      rd_data1 = regs_q[rd_addr1];
      if (latch_valid_q && latch_q.spec_valid && (latch_q.spec_dest == rd_addr1))
         rd_data1 = latch_q.spec_result;
      if (latch_valid_q && latch_q.write_en && (latch_q.dest == rd_addr1))
         rd_data1 = latch_q.result;

      rd_data2 = regs_q[rd_addr2];
      if (latch_valid_q && latch_q.spec_valid && (latch_q.spec_dest == rd_addr2))
         rd_data2 = latch_q.spec_result;
      if (latch_valid_q && latch_q.write_en && (latch_q.dest == rd_addr2))
         rd_data2 = latch_q.result;
   end

   // Scoreboard busy vector and sticky error output.
   always_comb begin
      for (int i = 0; i < NR; i++) reg_busy[i] = (cnt_q[i] != 2'd0);
      sb_error = sb_error_q;
   end

endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_writeback_regfile;

   localparam int SBM = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        ex_valid, ex_ready, ex_write_en, ex_dest_reg_special_valid;
   logic [3:0]  ex_dest_reg, ex_dest_reg_special;
   logic [63:0] ex_alu_result, ex_alu_result_special;
   logic        wb_stall;
   logic        iss_valid, iss_ready, iss_write_en, iss_dest_special_valid;
   logic [3:0]  iss_dest_reg, iss_dest_special;
   logic [15:0] reg_busy;
   logic [3:0]  rd_addr1, rd_addr2;
   logic [63:0] rd_data1, rd_data2;
   logic        sb_error;

   always #5 clk = ~clk;

   writeback_regfile dut (
      .clk(clk), .reset(reset),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_write_en(ex_write_en),
      .ex_dest_reg(ex_dest_reg), .ex_alu_result(ex_alu_result),
      .ex_dest_reg_special_valid(ex_dest_reg_special_valid),
      .ex_dest_reg_special(ex_dest_reg_special),
      .ex_alu_result_special(ex_alu_result_special),
      .wb_stall(wb_stall),
      .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_write_en(iss_write_en),
      .iss_dest_reg(iss_dest_reg), .iss_dest_special_valid(iss_dest_special_valid),
      .iss_dest_special(iss_dest_special),
      .reg_busy(reg_busy),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(rd_data1), .rd_data2(rd_data2),
      .sb_error(sb_error)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      bit        we;
      bit [3:0]  d;
      bit [63:0] r;
      bit        sv;
      bit [3:0]  sd;
      bit [63:0] sr;
   } wb_t;

   logic [63:0] regs_m [16];
   int          cnt_m  [16];
   bit          err_m;
   wb_t         lq [$];
   bit          exp_exr, exp_issr;

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         regs_m[i] = (i == 4) ? 64'h0000_0000_0000_F000 : 64'd0;
         cnt_m[i]  = 0;
      end
      err_m = 1'b0;
      lq.delete();
   endtask

   function automatic logic [63:0] model_read(input logic [3:0] a);
      if (lq.size() != 0 && lq[0].we && lq[0].d == a) return lq[0].r;
      if (lq.size() != 0 && lq[0].sv && lq[0].sd == a) return lq[0].sr;
      return regs_m[a];
   endfunction

   task automatic model_update();
      bit [15:0] incm;
      bit [15:0] decm;
      wb_t       e;
      if (!reset) begin
         model_reset();
         return;
      end
      incm = '0;
      decm = '0;
      if (iss_valid && exp_issr) begin
         if (iss_write_en)           incm[iss_dest_reg]     = 1'b1;
         if (iss_dest_special_valid) incm[iss_dest_special] = 1'b1;
      end
      if (lq.size() != 0 && !wb_stall) begin
         e = lq.pop_front();
         if (e.sv) begin regs_m[e.sd] = e.sr; decm[e.sd] = 1'b1; end
         if (e.we) begin regs_m[e.d]  = e.r;  decm[e.d]  = 1'b1; end
         if (e.we && e.sv && e.d == e.sd) err_m = 1'b1;
      end
      if (ex_valid && exp_exr) begin
         e.we = ex_write_en;  e.d  = ex_dest_reg;         e.r  = ex_alu_result;
         e.sv = ex_dest_reg_special_valid; e.sd = ex_dest_reg_special; e.sr = ex_alu_result_special;
         lq.push_back(e);
      end
      for (int i = 0; i < 16; i++) begin
         if (decm[i] && cnt_m[i] == 0) err_m = 1'b1;
         cnt_m[i] = cnt_m[i] + int'(incm[i]) - int'(decm[i]);
         if (cnt_m[i] < 0) cnt_m[i] = 0;
      end
   endtask

   // One clock: compare outputs mid-cycle, then advance model on the edge.
   task automatic cycle();
      logic [15:0] busy_e;
      #1;
      exp_exr  = reset && (lq.size() == 0 || !wb_stall);
      exp_issr = reset && !((iss_write_en && cnt_m[iss_dest_reg] == SBM) ||
                            (iss_dest_special_valid && cnt_m[iss_dest_special] == SBM));
      for (int i = 0; i < 16; i++) busy_e[i] = (cnt_m[i] != 0);
      check("ex_ready",  64'(ex_ready),  64'(exp_exr));
      check("iss_ready", 64'(iss_ready), 64'(exp_issr));
      check("reg_busy",  64'(reg_busy),  64'(busy_e));
      check("rd_data1",  rd_data1, model_read(rd_addr1));
      check("rd_data2",  rd_data2, model_read(rd_addr2));
      check("sb_error",  64'(sb_error),  64'(err_m));
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic set_idle();
      reset = 1'b1;   wb_stall = 1'b0;
      ex_valid = 1'b0; ex_write_en = 1'b0; ex_dest_reg = '0; ex_alu_result = '0;
      ex_dest_reg_special_valid = 1'b0; ex_dest_reg_special = '0; ex_alu_result_special = '0;
      iss_valid = 1'b0; iss_write_en = 1'b0; iss_dest_reg = '0;
      iss_dest_special_valid = 1'b0; iss_dest_special = '0;
      rd_addr1 = '0; rd_addr2 = '0;
   endtask

   task automatic do_issue(input bit we, input logic [3:0] d, input bit sv, input logic [3:0] sd);
      iss_valid = 1'b1; iss_write_en = we; iss_dest_reg = d;
      iss_dest_special_valid = sv; iss_dest_special = sd;
      cycle();
      iss_valid = 1'b0;
   endtask

   task automatic set_ex(input bit we, input logic [3:0] d, input logic [63:0] r,
                         input bit sv, input logic [3:0] sd, input logic [63:0] sr);
      ex_valid = 1'b1; ex_write_en = we; ex_dest_reg = d; ex_alu_result = r;
      ex_dest_reg_special_valid = sv; ex_dest_reg_special = sd; ex_alu_result_special = sr;
   endtask

   initial begin
      set_idle();
      reset = 1'b0;
      @(posedge clk);
      @(posedge clk);
      model_reset();
      @(negedge clk);
      cycle();                       // reset still low: readies must be 0

      // Reset release with no traffic.
      reset = 1'b1; rd_addr1 = 4'd4; rd_addr2 = 4'd0;
      #1;
      check("rst_rsp",   rd_data1, 64'hF000);
      check("rst_reg0",  rd_data2, 64'h0);
      check("rst_busy",  64'(reg_busy), 64'h0);
      check("rst_exr",   64'(ex_ready), 64'h1);
      check("rst_issr",  64'(iss_ready), 64'h1);
      cycle();

      // Single write to RAX with bypass.
      do_issue(1'b1, 4'd0, 1'b0, 4'd0);
      set_ex(1'b1, 4'd0, 64'h1234, 1'b0, 4'd0, 64'h0);
      cycle();                       // accept edge
      ex_valid = 1'b0; rd_addr1 = 4'd0;
      #1;
      check("byp_data", rd_data1, 64'h1234);
      check("byp_busy", 64'(reg_busy[0]), 64'h1);
      cycle();                       // commit edge
      #1;
      check("cmt_data", rd_data1, 64'h1234);
      check("cmt_busy", 64'(reg_busy[0]), 64'h0);

      // MUL-style dual write.
      do_issue(1'b1, 4'd0, 1'b1, 4'd2);
      set_ex(1'b1, 4'd0, 64'h5, 1'b1, 4'd2, 64'h2);
      cycle();
      ex_valid = 1'b0;
      cycle();
      rd_addr1 = 4'd0; rd_addr2 = 4'd2;
      #1;
      check("mul_lo",   rd_data1, 64'h5);
      check("mul_hi",   rd_data2, 64'h2);
      check("mul_busy", 64'(reg_busy), 64'h0);

      // Stall with full latch, then commit+accept on one edge.
      do_issue(1'b1, 4'd3, 1'b0, 4'd0);
      do_issue(1'b1, 4'd3, 1'b0, 4'd0);
      wb_stall = 1'b1;
      set_ex(1'b1, 4'd3, 64'hA, 1'b0, 4'd0, 64'h0);
      cycle();
      ex_alu_result = 64'hB; rd_addr1 = 4'd3;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("stall_exr",  64'(ex_ready), 64'h0);
         check("stall_byp",  rd_data1, 64'hA);
         cycle();
      end
      wb_stall = 1'b0;
      cycle();                       // commit 0xA, accept 0xB
      ex_valid = 1'b0;
      cycle();                       // commit 0xB
      #1;
      check("b2b_data", rd_data1, 64'hB);
      check("b2b_busy", 64'(reg_busy[3]), 64'h0);

      // Scoreboard saturation on reg5.
      for (int k = 0; k < 3; k++) do_issue(1'b1, 4'd5, 1'b0, 4'd0);
      iss_valid = 1'b1;
      #1;
      check("sat_issr", 64'(iss_ready), 64'h0);
      cycle();
      iss_valid = 1'b0;
      set_ex(1'b1, 4'd5, 64'h55, 1'b0, 4'd0, 64'h0);
      cycle();                       // accept
      ex_valid = 1'b0;
      cycle();                       // commit: count 3 -> 2
      set_ex(1'b1, 4'd5, 64'h56, 1'b0, 4'd0, 64'h0);
      cycle();                       // accept
      ex_valid = 1'b0; iss_valid = 1'b1;
      #1;
      check("same_issr", 64'(iss_ready), 64'h1);
      cycle();                       // commit + issue on reg5: count stays 2
      iss_valid = 1'b0;
      #1;
      check("same_busy", 64'(reg_busy[5]), 64'h1);

      // Duplicate destination, stray commit, reset mid-stream.
      do_issue(1'b1, 4'd7, 1'b0, 4'd0);
      set_ex(1'b1, 4'd7, 64'h11, 1'b1, 4'd7, 64'h22);
      cycle();
      ex_valid = 1'b0;
      cycle();
      rd_addr1 = 4'd7;
      #1;
      check("dup_data", rd_data1, 64'h11);
      check("dup_err",  64'(sb_error), 64'h1);
      check("dup_busy", 64'(reg_busy[7]), 64'h0);
      set_ex(1'b1, 4'd8, 64'h88, 1'b0, 4'd0, 64'h0);
      cycle();
      ex_valid = 1'b0;
      cycle();
      #1;
      check("stray_err",  64'(sb_error), 64'h1);
      check("stray_busy", 64'(reg_busy[8]), 64'h0);
      do_issue(1'b1, 4'd9, 1'b0, 4'd0);
      wb_stall = 1'b1;
      set_ex(1'b1, 4'd9, 64'h99, 1'b0, 4'd0, 64'h0);
      cycle();                       // latch holds reg9
      ex_valid = 1'b0; reset = 1'b0;
      cycle();                       // reset edge
      reset = 1'b1; wb_stall = 1'b0; rd_addr1 = 4'd9;
      #1;
      check("rst2_err",  64'(sb_error), 64'h0);
      check("rst2_busy", 64'(reg_busy), 64'h0);
      check("rst2_data", rd_data1, 64'h0);
      check("rst2_exr",  64'(ex_ready), 64'h1);
      cycle();

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         reset                     = ($urandom_range(0, 79) != 0);
         wb_stall                  = ($urandom_range(0, 3) == 0);
         ex_valid                  = $urandom_range(0, 1) == 1;
         ex_write_en               = ($urandom_range(0, 3) != 0);
         ex_dest_reg               = 4'($urandom_range(0, 7));
         ex_alu_result             = {$urandom(), $urandom()};
         ex_dest_reg_special_valid = ($urandom_range(0, 3) == 0);
         ex_dest_reg_special       = 4'($urandom_range(0, 7));
         ex_alu_result_special     = {$urandom(), $urandom()};
         iss_valid                 = $urandom_range(0, 1) == 1;
         iss_write_en              = ($urandom_range(0, 3) != 0);
         iss_dest_reg              = 4'($urandom_range(0, 7));
         iss_dest_special_valid    = ($urandom_range(0, 3) == 0);
         iss_dest_special          = 4'($urandom_range(0, 7));
         rd_addr1                  = 4'($urandom_range(0, 15));
         rd_addr2                  = 4'($urandom_range(0, 15));
         if (lq.size() != 0 && $urandom_range(0, 1) == 1) rd_addr1 = lq[0].d;
         if (lq.size() != 0 && $urandom_range(0, 1) == 1) rd_addr2 = lq[0].sd;
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
